// File: rtl/sw_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sw_pkg
//  Description : Shared definitions for the Smith-Waterman feeder and scorer:
//                2-bit nucleotide codes, default job lengths, FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package sw_pkg;

    // Default job geometry (reference bases / query bases per job)
    localparam int REF_LEN_DEF   = 64;
    localparam int QUERY_LEN_DEF = 48;

    // 2-bit nucleotide codes shared with the scorer
    localparam logic [1:0] BASE_A = 2'd0;
    localparam logic [1:0] BASE_C = 2'd1;
    localparam logic [1:0] BASE_G = 2'd2;
    localparam logic [1:0] BASE_T = 2'd3;

    // Loader states: accept host bases, or stream a complete job to the scorer
    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } sw_state_t;

endpackage
`default_nettype wire

// File: rtl/sw_base_encode.sv
`default_nettype none
// ============================================================================
//  Module      : sw_base_encode
//  Description : Combinational ASCII nucleotide encoder. Upper and lower case
//                map to the same code; anything else yields code A and bad=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module sw_base_encode
    import sw_pkg::*;
(
    input  logic [7:0] i_char,
    output logic [1:0] o_code,
    output logic       o_bad
);

    // Case-insensitive ACGT lookup; unknown characters are flagged, not dropped
    always_comb begin
        o_code = BASE_A;
        o_bad  = 1'b0;
        case (i_char)
            8'h41, 8'h61: o_code = BASE_A;   // 'A' / 'a'
            8'h43, 8'h63: o_code = BASE_C;   // 'C' / 'c'
            8'h47, 8'h67: o_code = BASE_G;   // 'G' / 'g'
            8'h54, 8'h74: o_code = BASE_T;   // 'T' / 't'
            default:      o_bad  = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/sw_seq_loader.sv
`default_nettype none
// ============================================================================
//  Module      : sw_seq_loader
//  Description : Host-side feeder for the Smith-Waterman scorer. Buffers one
//                reference and one query sequence (2-bit encoded) and streams
//                them as one REF_LEN-cycle burst, never overlapping a job the
//                scorer is still computing.
//  Revision    : 1.0 - initial release
// ============================================================================
module sw_seq_loader
    import sw_pkg::*;
#(
    parameter int REF_LEN   = REF_LEN_DEF,
    parameter int QUERY_LEN = QUERY_LEN_DEF,
    parameter int CNT_W     = 7
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_sel,
    input  logic [7:0] in_base,
    input  logic       flush,
    input  logic       sw_finish,
    output logic       valid,
    output logic [1:0] data_ref,
    output logic [1:0] data_query,
    output logic       busy,
    output logic       err_char
);

    localparam int               RIDX_W     = $clog2(REF_LEN);
    localparam int               QIDX_W     = $clog2(QUERY_LEN);
    localparam logic [CNT_W-1:0] c_REF_FULL = CNT_W'(REF_LEN);
    localparam logic [CNT_W-1:0] c_QRY_FULL = CNT_W'(QUERY_LEN);

    sw_state_t        r_state;
    sw_state_t        w_state_nxt;

    logic [1:0]       r_ref_buf [REF_LEN];
    logic [1:0]       r_qry_buf [QUERY_LEN];
    logic [CNT_W-1:0] r_ref_cnt;
    logic [CNT_W-1:0] r_qry_cnt;
    logic [CNT_W-1:0] r_k;

    logic             r_busy;
    logic             r_err;
    logic             r_valid;
    logic [1:0]       r_data_ref;
    logic [1:0]       r_data_qry;

    logic [1:0]       w_code;
    logic             w_bad;
    logic             w_ref_room;
    logic             w_qry_room;
    logic             w_accept;
    logic             w_acc_ref;
    logic             w_acc_qry;
    logic             w_start;
    logic             w_stream_done;

    sw_base_encode u_encode (
        .i_char (in_base),
        .o_code (w_code),
        .o_bad  (w_bad)
    );

    // A full buffer only back-pressures its own selector
    assign w_ref_room = (r_ref_cnt < c_REF_FULL);
    assign w_qry_room = (r_qry_cnt < c_QRY_FULL);
    assign in_ready   = (r_state == FILL) && (in_sel ? w_qry_room : w_ref_room);

    // A base presented in the same cycle as flush is discarded with the rest
    assign w_accept   = in_valid && in_ready && !flush;
    assign w_acc_ref  = w_accept && !in_sel;
    assign w_acc_qry  = w_accept &&  in_sel;

    assign valid      = r_valid;
    assign data_ref   = r_data_ref;
    assign data_query = r_data_qry;
    assign busy       = r_busy;
    assign err_char   = r_err;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: start only with both buffers full, scorer idle and no flush
    always_comb begin
        w_state_nxt   = r_state;
        w_start       = 1'b0;
        w_stream_done = 1'b0;
        case (r_state)
            FILL: begin
                if ((r_ref_cnt == c_REF_FULL) && (r_qry_cnt == c_QRY_FULL) &&
                    !r_busy && !flush) begin
                    w_start     = 1'b1;
                    w_state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (r_k == c_REF_FULL) begin
                    w_stream_done = 1'b1;
                    w_state_nxt   = FILL;
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    // Base storage; contents are only read after a full load, so no reset
    always_ff @(posedge clk) begin
        if (w_acc_ref) begin
            r_ref_buf[r_ref_cnt[RIDX_W-1:0]] <= w_code;
        end
        if (w_acc_qry) begin
            r_qry_buf[r_qry_cnt[QIDX_W-1:0]] <= w_code;
        end
    end

    // Fill counters, sticky character error and scorer-busy tracking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ref_cnt <= '0;
            r_qry_cnt <= '0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            if ((r_state == FILL) && flush) begin
                r_ref_cnt <= '0;
                r_qry_cnt <= '0;
                r_err     <= 1'b0;
            end else begin
                if (w_acc_ref) begin
                    r_ref_cnt <= r_ref_cnt + 1'b1;
                end
                if (w_acc_qry) begin
                    r_qry_cnt <= r_qry_cnt + 1'b1;
                end
                if (w_accept && w_bad) begin
                    r_err <= 1'b1;
                end
            end
            if (w_start) begin
                r_err <= 1'b0;
            end
            if (w_stream_done) begin
                r_ref_cnt <= '0;
                r_qry_cnt <= '0;
            end
            // Setting busy wins; a finish pulse with nothing outstanding is ignored
            if (w_stream_done) begin
                r_busy <= 1'b1;
            end else if (sw_finish) begin
                r_busy <= 1'b0;
            end
        end
    end

    // Stream outputs: base 0 leaves on the start edge, then one base per cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid    <= 1'b0;
            r_data_ref <= 2'b00;
            r_data_qry <= 2'b00;
            r_k        <= '0;
        end else if (w_start) begin
            r_valid    <= 1'b1;
            r_data_ref <= r_ref_buf[0];
            r_data_qry <= r_qry_buf[0];
            r_k        <= CNT_W'(1);
        end else if ((r_state == STREAM) && !w_stream_done) begin
            r_valid    <= 1'b1;
            r_data_ref <= r_ref_buf[r_k[RIDX_W-1:0]];
            r_data_qry <= (r_k < c_QRY_FULL) ? r_qry_buf[r_k[QIDX_W-1:0]] : 2'b00;
            r_k        <= r_k + 1'b1;
        end else begin
            r_valid    <= 1'b0;
            r_data_ref <= 2'b00;
            r_data_qry <= 2'b00;
            r_k        <= '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sw_seq_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sw_seq_loader
//  Description : Scoreboard bench for sw_seq_loader. Stimulus loads jobs of
//                random bases and queues the expected stream beats; a monitor
//                pops and compares every cycle the loader drives valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sw_seq_loader;

    localparam int REF_LEN   = 64;
    localparam int QUERY_LEN = 48;

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b0;
    logic       in_valid  = 1'b0;
    logic       in_sel    = 1'b0;
    logic [7:0] in_base   = 8'h41;
    logic       flush     = 1'b0;
    logic       sw_finish = 1'b0;
    logic       in_ready;
    logic       valid;
    logic [1:0] data_ref;
    logic [1:0] data_query;
    logic       busy;
    logic       err_char;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] q;
    } beat_t;

    int         n_checks     = 0;
    int         n_fail       = 0;
    beat_t      sb[$];
    logic [1:0] m_ref[$];
    logic [1:0] m_qry[$];
    bit         m_err        = 1'b0;
    int         jobs_done    = 0;
    int         beats_in_job = 0;
    bit         abort        = 1'b0;

    always #5 clk = ~clk;

    sw_seq_loader #(
        .REF_LEN   (REF_LEN),
        .QUERY_LEN (QUERY_LEN),
        .CNT_W     (7)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_base    (in_base),
        .flush      (flush),
        .sw_finish  (sw_finish),
        .valid      (valid),
        .data_ref   (data_ref),
        .data_query (data_query),
        .busy       (busy),
        .err_char   (err_char)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Spec table: A/C/G/T -> 0..3 in either case; anything else -> 0 with error
    function automatic logic [2:0] enc(input byte ch);
        string up = "ACGT";
        for (int i = 0; i < 4; i++) begin
            if (ch == up[i] || ch == byte'(up[i] + 8'd32)) return {1'b0, 2'(i)};
        end
        return 3'b100;
    endfunction

    function automatic byte rand_base();
        string a = "ACGTacgt";
        return a[$urandom_range(0, 7)];
    endfunction

    // Hand one base to the loader, waiting (bounded) for in_ready
    task automatic push(input bit sel, input byte ch);
        int n;
        logic [2:0] e;
        @(negedge clk);
        in_valid = 1'b1;
        in_sel   = sel;
        in_base  = ch;
        #1;
        n = 0;
        while (in_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (in_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: in_ready=%b, expected 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e = enc(ch);
        if (sel) m_qry.push_back(e[1:0]);
        else     m_ref.push_back(e[1:0]);
        if (e[2]) m_err = 1'b1;
    endtask

    // Turn the buffered model job into expected stream beats
    task automatic commit();
        beat_t b;
        for (int k = 0; k < REF_LEN; k++) begin
            b.r = m_ref[k];
            b.q = (k < QUERY_LEN) ? m_qry[k] : 2'b00;
            sb.push_back(b);
        end
        m_ref.delete();
        m_qry.delete();
        m_err = 1'b0;
    endtask

    task automatic load_job(input bit alternate, input bit do_commit);
        if (alternate) begin
            for (int i = 0; i < REF_LEN; i++) begin
                push(1'b0, rand_base());
                if (i < QUERY_LEN) push(1'b1, rand_base());
            end
        end else begin
            for (int i = 0; i < REF_LEN; i++)   push(1'b0, rand_base());
            for (int i = 0; i < QUERY_LEN; i++) push(1'b1, rand_base());
        end
        if (do_commit) commit();
    endtask

    task automatic probe(input bit sel, input logic exp, input string name);
        @(negedge clk);
        in_valid = 1'b1;
        in_sel   = sel;
        in_base  = 8'h41;
        #1;
        check(name, in_ready, exp);
        in_valid = 1'b0;
    endtask

    task automatic pulse_finish();
        @(negedge clk);
        sw_finish = 1'b1;
        @(negedge clk);
        sw_finish = 1'b0;
    endtask

    task automatic wait_jobs(input int n);
        int t = 0;
        while (jobs_done < n && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (jobs_done < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL job_timeout: jobs_done=%0d, expected %0d", jobs_done, n);
        end
    endtask

    task automatic quiet_window(input int cycles, input string name);
        int highs = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (valid === 1'b1) highs++;
        end
        check(name, highs, 0);
    endtask

    // Monitor: every valid cycle must match the next queued beat
    initial begin
        beat_t b;
        logic  prev_valid = 1'b0;
        int    run_len    = 0;
        forever begin
            @(negedge clk);
            if (valid === 1'b1) begin
                if (!prev_valid) check("err_clear_on_entry", err_char, 0);
                run_len++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: valid=1 with no job expected (t=%0t)", $time);
                end else begin
                    b = sb.pop_front();
                    check("data_ref", data_ref, b.r);
                    check("data_query", data_query, b.q);
                end
                beats_in_job++;
            end else if (prev_valid) begin
                if (abort) begin
                    abort = 1'b0;
                end else begin
                    check("valid_length", run_len, REF_LEN);
                    check("busy_after_stream", busy, 1);
                    jobs_done++;
                end
                run_len      = 0;
                beats_in_job = 0;
            end
            prev_valid = valid;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        string ref_pat = "ACGT";
        string qry_pat = "TTGCA";
        string lower   = "acgTg";

        // ---------------- reset values ----------------
        repeat (3) @(negedge clk);
        check("rst_valid", valid, 0);
        check("rst_data_ref", data_ref, 0);
        check("rst_data_query", data_query, 0);
        check("rst_busy", busy, 0);
        check("rst_err_char", err_char, 0);
        check("rst_in_ready", in_ready, 1);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);

        // ---------------- basic job ----------------
        for (int i = 0; i < REF_LEN; i++) push(1'b0, ref_pat[i % 4]);
        for (int i = 0; i < QUERY_LEN; i++) push(1'b1, (i < 5) ? qry_pat[i] : rand_base());
        commit();
        @(negedge clk);
        check("start_not_yet", valid, 0);
        @(negedge clk);
        check("start_latency", valid, 1);
        wait_jobs(1);

        // ---------------- interleaved load held while busy ----------------
        for (int i = 0; i < 40; i++) begin
            push(1'b0, rand_base());
            push(1'b1, rand_base());
        end
        for (int i = 0; i < 24; i++) push(1'b0, rand_base());
        probe(1'b0, 1'b0, "ref_full_backpressure");
        probe(1'b1, 1'b1, "qry_still_ready");
        for (int i = 0; i < 8; i++) push(1'b1, rand_base());
        probe(1'b1, 1'b0, "qry_full_backpressure");
        commit();
        quiet_window(10, "held_while_busy");
        check("busy_held", busy, 1);
        @(negedge clk);
        sw_finish = 1'b1;
        @(posedge clk);
        #1;
        sw_finish = 1'b0;
        @(negedge clk);
        check("no_valid_after_finish_edge", valid, 0);
        @(negedge clk);
        check("valid_two_after_finish", valid, 1);
        wait_jobs(2);

        // ---------------- bad character / lowercase ----------------
        pulse_finish();
        for (int i = 0; i < 5; i++) push(1'b0, lower[i]);
        @(negedge clk);
        check("lowercase_no_err", err_char, m_err);
        push(1'b0, "N");
        @(negedge clk);
        check("bad_char_err", err_char, 1);
        for (int i = 6; i < REF_LEN; i++) push(1'b0, rand_base());
        for (int i = 0; i < QUERY_LEN; i++) push(1'b1, rand_base());
        commit();
        wait_jobs(3);

        // ---------------- flush after 30 bases ----------------
        pulse_finish();
        for (int i = 0; i < 20; i++) push(1'b0, (i == 3) ? 8'h78 : rand_base());
        for (int i = 0; i < 10; i++) push(1'b1, rand_base());
        @(negedge clk);
        check("pre_flush_err", err_char, m_err);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        m_ref.delete();
        m_qry.delete();
        m_err = 1'b0;
        check("flush_clears_err", err_char, m_err);
        load_job($urandom_range(0, 1) == 1, 1'b1);
        wait_jobs(4);

        // ---------------- flush on the start-condition cycle ----------------
        pulse_finish();
        load_job(1'b0, 1'b0);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        m_ref.delete();
        m_qry.delete();
        m_err = 1'b0;
        quiet_window(8, "flush_beats_start");
        probe(1'b0, 1'b1, "flush_ref_empty");
        probe(1'b1, 1'b1, "flush_qry_empty");

        // ---------------- reset in the middle of a stream ----------------
        load_job(1'b1, 1'b1);
        begin
            int t = 0;
            while (beats_in_job < 20 && t < 400) begin
                @(negedge clk);
                #2;
                t++;
            end
            check("reached_stream_cycle_20", beats_in_job, 20);
        end
        abort   = 1'b1;
        reset_n = 1'b0;
        #1;
        check("rst_mid_valid", valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_data_ref", data_ref, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        in_sel  = 1'b0;
        #1;
        check("rst_mid_in_ready", in_ready, 1);
        check("rst_mid_busy_after", busy, 0);
        repeat (4) @(negedge clk);
        check("rst_mid_no_restart", valid, 0);

        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
